// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: FSM encoding, default buffer depth and width helper
// shared by the fifo_reader top, its elastic buffer and the interface.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_BUF_DEPTH = 3;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: valid/ready output stream of the FIFO reader.
// Signals: m_data, m_valid, m_last (master out), m_ready (master in).
interface fifo_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int W = 16
) ();

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: circular elastic buffer absorbing FIFO read latency.
// Ports: clk, rst, push/din (write), pop (read), dout (head), occ (fill).
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = DEF_BUF_DEPTH,
  localparam int PW    = cw(DEPTH),
  localparam int OW    = cw(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;
  logic          full;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (occ != '0);
  assign full   = (occ == OW'(DEPTH));

  // Head is forced to zero while empty so the
  // stream data reads zero out of reset.
  assign dout = (occ != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      if (push && !do_pop)
        occ <= occ + 1'b1;
      else if (do_pop && !push)
        occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // Issue throttling keeps occ + inflight within
  // DEPTH, so a push can never meet a full buffer.
  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full)
  );

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains len words from a FIFO onto a valid/ready stream.
// Ports: clk, rst, start/len/busy/done (control), fifo_* (FIFO read
// port), m (stream master), err (sticky underflow, FIFO_READER_ERR_EN).
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_reader_if.master         m,
  output logic                  err
);

  localparam int OW = cw(BUF_DEPTH + 1);

  state_t          state;
  state_t          state_nxt;
  logic [LEN_W-1:0] rem_issue;
  logic [LEN_W-1:0] rem_out;
  logic            inflight;
  logic [OW-1:0]   occ;
  logic [OW:0]     pend;
  logic            pop;
  logic [FIFO_WIDTH-1:0] head;

  // Words already committed to the buffer:
  // stored ones plus the one still in flight.
  assign pend = {1'b0, occ}
              + {{OW{1'b0}}, inflight};

  assign fifo_rd_en = (state == RUN)
                   && !fifo_empty
                   && (rem_issue != '0)
                   && (pend < (OW+1)'(BUF_DEPTH))
                   && !rst;

  assign m.m_valid = (occ != '0);
  assign m.m_data  = head;
  assign m.m_last  = m.m_valid
                  && (rem_out == LEN_W'(1));
  assign pop       = m.m_valid && m.m_ready;

  fifo_reader_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_data_out),
    .pop  (pop),
    .dout (head),
    .occ  (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_issue <= '0;
      rem_out   <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (state == IDLE && start) begin
        rem_issue <= len;
        rem_out   <= len;
      end else begin
        if (fifo_rd_en)
          rem_issue <= rem_issue - 1'b1;
        if (pop)
          rem_out <= rem_out - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (fifo_rd_en && rem_issue == LEN_W'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && rem_out == LEN_W'(1))
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_READER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (fifo_underflow)
      err <= 1'b1;
  end
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  assign err = 1'b0;
`endif

endmodule
